ext_io_bridge: RTL and testbench
================================

# ext_io_bridge

Parametrised bridge between the rv32 core's external-function ports (UART write/read, LED) and a byte-stream UART endpoint such as the USB serial block. Adds buffered TX and RX FIFOs of configurable depth, a configurable-width LED register with per-bit write mask, and FIFO level reporting. It sits in the FPGA top level between `rv32` and the UART, replacing direct wiring.

## Interface
- `DATA_W`, 8, byte width of the UART stream
- `TX_DEPTH`, 4, TX FIFO entries; power of two, ≥2
- `RX_DEPTH`, 4, RX FIFO entries; power of two, ≥2
- `LED_W`, 1, LED register width
- `LED_INIT`, 0, LED register reset value

Ports. Reset is asynchronous and active-low.
- `CLK` in 1: the single clock.
- `RST_N` in 1: asynchronous, active-low reset.
- `core_wr_valid` in 1: core TX write request.
- `core_wr_data` in DATA_W: TX byte.
- `core_wr_ready` out 1: TX FIFO can accept.
- `core_rd_ready` in 1: core pops an RX byte.
- `core_rd_valid` out 1: RX FIFO non-empty.
- `core_rd_data` out DATA_W: RX FIFO head.
- `core_led_valid` in 1: LED write strobe.
- `core_led_data` in LED_W: LED write value.
- `core_led_mask` in LED_W: per-bit write enable.
- `core_led_out` out LED_W: current LED register.
- `uart_in_data` out DATA_W: byte to the UART transmitter.
- `uart_in_valid` out 1: TX FIFO non-empty.
- `uart_in_ready` in 1: UART accepts the byte.
- `uart_out_data` in DATA_W: byte from the UART receiver.
- `uart_out_valid` in 1: UART byte present.
- `uart_out_ready` out 1: RX FIFO can accept.
- `tx_level` out clog2(TX_DEPTH)+1: TX occupancy.
- `rx_level` out clog2(RX_DEPTH)+1: RX occupancy.
- `LED` out LED_W: pin drive, equal to `core_led_out`.

## Operation
- Both FIFOs use registered storage, with read and write pointers one bit wider than the index (wrap bit).
  - Empty: pointers are equal.
  - Full: indices are equal and the wrap bits differ.
- TX push: `core_wr_valid && core_wr_ready`. `core_wr_ready = !tx_full`, with no same-cycle pop bypass.
- TX pop: `uart_in_valid && uart_in_ready`. `uart_in_valid = !tx_empty`, and `uart_in_data` shows the head entry.
- RX push: `uart_out_valid && uart_out_ready`. `uart_out_ready = !rx_full`; the UART is back-pressured and no bytes are dropped.
- RX pop: `core_rd_ready && core_rd_valid`. A pop on empty has no effect. `core_rd_data` shows the head entry; its value while empty is don't-care but stable.
- Simultaneous push and pop on the same FIFO (legal when neither full nor empty) leaves the level unchanged. Pointers wrap modulo 2·DEPTH.
- Levels: `level = wptr − rptr` in pointer width. Range is 0…DEPTH inclusive.
- LED: on `core_led_valid`, `led <= (led & ~mask) | (data & mask)`. With mask all ones this is a plain write.
- Asserting `RST_N` low mid-operation immediately empties both FIFOs, sets `led = LED_INIT`, and discards any byte in flight.
  - Reset values of outputs: `core_wr_ready=1`, `core_rd_valid=0`, `uart_in_valid=0`, `uart_out_ready=1`, levels 0, `core_led_out=LED=LED_INIT`.
- Reset deassertion must be synchronised by the top level. The bridge itself is purely asynchronous-reset.

## Timing
- All ready/valid outputs are combinational from registered pointers only, with no input-to-output combinational path.
- TX latency: a byte accepted at edge N is visible on `uart_in_valid`/`uart_in_data` after edge N.
- RX latency: a byte accepted at edge N is visible on `core_rd_valid` after edge N.
- Levels and LED update at the same edge as the accepting handshake.
- Sustained throughput is one byte/cycle per direction when the far side is always ready.

## Configuration
- `EXT_IO_BRIDGE_LOOPBACK_EN`
  - Defined: adds an input port `loopback` (1 bit). While `loopback=1`:
    - The TX FIFO head feeds the RX FIFO push (pop TX and push RX when `!tx_empty && !rx_full`).
    - `uart_in_valid=0` and `uart_out_ready=0`.
    - Changing `loopback` takes effect at the next edge; no byte is lost or duplicated.
  - Undefined: no `loopback` port; the UART path only.

## Test plan
- Reset with `LED_INIT=1`, `LED_W=4` -> all outputs at the reset values above, `LED=4'b0001`, levels 0.
- With `TX_DEPTH=4` and `uart_in_ready=0`, write 0x11,0x22,0x33,0x44,0x55 -> first four accepted, `core_wr_ready=0`, `tx_level=4`, 0x55 refused. Then `uart_in_ready=1` -> UART receives 11,22,33,44 on consecutive cycles.
- RX: UART sends 0xA0…0xA5 with `core_rd_ready=0` -> `uart_out_ready` drops after four bytes, `rx_level=4`. Pop -> 0xA0 first and in order; 0xA4 is accepted one cycle after the pop.
- Concurrent push+pop at level 2 over 20 cycles, crossing pointer wrap -> level stays 2, data in order.
- LED `LED_W=4`: write data=1111 mask=0101, then data=0000 mask=0001 -> LED=0101 then 0100.
- Loopback build, `loopback=1`: core writes 0x5A -> `core_rd_data=0x5A` and `uart_in_valid` is never 1. Assert `RST_N` low mid-transfer -> both FIFOs are empty at once.

Source files
------------

// File: rtl/ext_io_bridge_if.sv
// Byte-stream and LED bundle between the rv32 external-function ports and a UART endpoint.
// Handshake: a byte moves on a rising edge where valid && ready; valid holds its data until taken.
interface ext_io_bridge_if #(
   parameter int DATA_W = 8,
   parameter int LED_W  = 1
);
   // core TX write port
   logic              core_wr_valid;
   logic [DATA_W-1:0] core_wr_data;
   logic              core_wr_ready;
   // core RX read port
   logic              core_rd_ready;
   logic              core_rd_valid;
   logic [DATA_W-1:0] core_rd_data;
   // core LED write port
   logic              core_led_valid;
   logic [LED_W-1:0]  core_led_data;
   logic [LED_W-1:0]  core_led_mask;
   logic [LED_W-1:0]  core_led_out;
   // UART transmitter side
   logic [DATA_W-1:0] uart_in_data;
   logic              uart_in_valid;
   logic              uart_in_ready;
   // UART receiver side
   logic [DATA_W-1:0] uart_out_data;
   logic              uart_out_valid;
   logic              uart_out_ready;

   modport slave (
      input  core_wr_valid, core_wr_data, core_rd_ready,
      input  core_led_valid, core_led_data, core_led_mask,
      input  uart_in_ready, uart_out_data, uart_out_valid,
      output core_wr_ready, core_rd_valid, core_rd_data, core_led_out,
      output uart_in_data, uart_in_valid, uart_out_ready
   );

   modport master (
      output core_wr_valid, core_wr_data, core_rd_ready,
      output core_led_valid, core_led_data, core_led_mask,
      output uart_in_ready, uart_out_data, uart_out_valid,
      input  core_wr_ready, core_rd_valid, core_rd_data, core_led_out,
      input  uart_in_data, uart_in_valid, uart_out_ready
   );
endinterface

// File: rtl/ext_io_bridge.sv
// Buffered core<->UART bridge: TX/RX FIFOs, masked LED register, occupancy levels.
// Optional TX->RX internal loopback when EXT_IO_BRIDGE_LOOPBACK_EN is defined.
module ext_io_bridge_fifo #(
   parameter int W     = 8,
   parameter int DEPTH = 4
) (
   input  logic                     i_clk,
   input  logic                     i_rst_n,
   input  logic                     i_push,
   input  logic [W-1:0]             i_push_data,
   input  logic                     i_pop,
   output logic                     o_empty,
   output logic                     o_full,
   output logic [W-1:0]             o_head,
   output logic [$clog2(DEPTH):0]   o_level
);
   localparam int AW = $clog2(DEPTH);

   logic [AW:0]  r_wptr;
   logic [AW:0]  r_rptr;
   logic [W-1:0] r_mem [DEPTH];
   logic         w_push;
   logic         w_pop;

   // Extra top pointer bit distinguishes full from empty when indices match.
   assign o_empty = (r_wptr == r_rptr);
   assign o_full  = (r_wptr[AW-1:0] == r_rptr[AW-1:0]) && (r_wptr[AW] != r_rptr[AW]);
   assign o_head  = r_mem[r_rptr[AW-1:0]];
   assign o_level = r_wptr - r_rptr;

   assign w_push = i_push && !o_full;
   assign w_pop  = i_pop && !o_empty;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_wptr <= '0;
         r_rptr <= '0;
      end else begin
         if (w_push) r_wptr <= r_wptr + 1'b1;
         if (w_pop)  r_rptr <= r_rptr + 1'b1;
      end
   end

   always_ff @(posedge i_clk) begin
      if (w_push) r_mem[r_wptr[AW-1:0]] <= i_push_data;
   end
endmodule

module ext_io_bridge #(
   parameter int             DATA_W   = 8,
   parameter int             TX_DEPTH = 4,
   parameter int             RX_DEPTH = 4,
   parameter int             LED_W    = 1,
   parameter logic [LED_W-1:0] LED_INIT = '0
) (
   input  logic                          CLK,
   input  logic                          RST_N,
`ifdef EXT_IO_BRIDGE_LOOPBACK_EN
   input  logic                          loopback,
`endif
   ext_io_bridge_if.slave                bus,
   output logic [$clog2(TX_DEPTH):0]     tx_level,
   output logic [$clog2(RX_DEPTH):0]     rx_level,
   output logic [LED_W-1:0]              LED
);
   logic              w_lb;
   logic              w_tx_empty;
   logic              w_tx_full;
   logic [DATA_W-1:0] w_tx_head;
   logic              w_tx_pop;
   logic              w_rx_empty;
   logic              w_rx_full;
   logic [DATA_W-1:0] w_rx_head;
   logic              w_rx_push;
   logic [DATA_W-1:0] w_rx_din;
   logic              w_rx_pop;
   logic              w_lb_xfer;
   logic [LED_W-1:0]  r_led;

`ifdef EXT_IO_BRIDGE_LOOPBACK_EN
   // Mode is registered so a change applies from the next edge and never splits a byte.
   logic r_loopback;
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) r_loopback <= 1'b0;
      else        r_loopback <= loopback;
   end
   assign w_lb = r_loopback;
`else
   assign w_lb = 1'b0;
`endif

   assign w_lb_xfer = w_lb && !w_tx_empty && !w_rx_full;
   assign w_tx_pop  = (!w_lb && !w_tx_empty && bus.uart_in_ready) || w_lb_xfer;
   assign w_rx_push = (!w_lb && !w_rx_full && bus.uart_out_valid) || w_lb_xfer;
   assign w_rx_din  = w_lb ? w_tx_head : bus.uart_out_data;
   assign w_rx_pop  = bus.core_rd_ready && !w_rx_empty;

   ext_io_bridge_fifo #(.W(DATA_W), .DEPTH(TX_DEPTH)) u_tx_fifo (
      .i_clk       (CLK),
      .i_rst_n     (RST_N),
      .i_push      (bus.core_wr_valid),
      .i_push_data (bus.core_wr_data),
      .i_pop       (w_tx_pop),
      .o_empty     (w_tx_empty),
      .o_full      (w_tx_full),
      .o_head      (w_tx_head),
      .o_level     (tx_level)
   );

   ext_io_bridge_fifo #(.W(DATA_W), .DEPTH(RX_DEPTH)) u_rx_fifo (
      .i_clk       (CLK),
      .i_rst_n     (RST_N),
      .i_push      (w_rx_push),
      .i_push_data (w_rx_din),
      .i_pop       (w_rx_pop),
      .o_empty     (w_rx_empty),
      .o_full      (w_rx_full),
      .o_head      (w_rx_head),
      .o_level     (rx_level)
   );

   // Handshake outputs depend only on registered pointers and mode.
   assign bus.core_wr_ready  = !w_tx_full;
   assign bus.uart_in_valid  = !w_tx_empty && !w_lb;
   assign bus.uart_in_data   = w_tx_head;
   assign bus.uart_out_ready = !w_rx_full && !w_lb;
   assign bus.core_rd_valid  = !w_rx_empty;
   assign bus.core_rd_data   = w_rx_head;

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N)                  r_led <= LED_INIT;
      else if (bus.core_led_valid) r_led <= (r_led & ~bus.core_led_mask) |
                                            (bus.core_led_data & bus.core_led_mask);
   end

   assign bus.core_led_out = r_led;
   assign LED              = r_led;
endmodule

// File: tb/tb_ext_io_bridge.sv
// Self-checking bench for ext_io_bridge: queue-based reference model plus directed literal checks.
// Build with EXT_IO_BRIDGE_LOOPBACK_EN defined to also exercise the loopback mode.
module tb_ext_io_bridge;
   localparam int         DW    = 8;
   localparam int         TXD   = 4;
   localparam int         RXD   = 4;
   localparam int         LW    = 4;
   localparam logic [3:0] LINIT = 4'b0001;

   logic       CLK   = 1'b0;
   logic       RST_N = 1'b0;
   logic [2:0] tx_level;
   logic [2:0] rx_level;
   logic [3:0] LED;
`ifdef EXT_IO_BRIDGE_LOOPBACK_EN
   logic       loopback = 1'b0;
`endif

   ext_io_bridge_if #(.DATA_W(DW), .LED_W(LW)) bus ();

   ext_io_bridge #(
      .DATA_W(DW), .TX_DEPTH(TXD), .RX_DEPTH(RXD), .LED_W(LW), .LED_INIT(LINIT)
   ) dut (
      .CLK      (CLK),
      .RST_N    (RST_N),
`ifdef EXT_IO_BRIDGE_LOOPBACK_EN
      .loopback (loopback),
`endif
      .bus      (bus),
      .tx_level (tx_level),
      .rx_level (rx_level),
      .LED      (LED)
   );

   always #5 CLK = ~CLK;

   int n_tests = 0;
   int n_fail  = 0;

   // Scoreboard: expected FIFO contents and logs of bytes leaving each side.
   logic [DW-1:0] tx_exp_q[$];
   logic [DW-1:0] rx_exp_q[$];
   logic [DW-1:0] uart_log[$];
   logic [DW-1:0] core_log[$];
   logic [LW-1:0] led_exp = LINIT;
   logic          lb_mode = 1'b0;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
      end
   endtask

   task automatic timeout_fail(input string name);
      n_tests++;
      n_fail++;
      $display("FAIL %s: timed out at %0t", name, $time);
   endtask

   // Reference model: bytes move between queues according to handshakes seen at the edge.
   always @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         tx_exp_q.delete();
         rx_exp_q.delete();
         led_exp = LINIT;
         lb_mode = 1'b0;
      end else begin
         bit tx_push, tx_pop, rx_push, rx_pop;
         logic [DW-1:0] b;
         tx_push = bus.core_wr_valid && (tx_exp_q.size() < TXD);
         tx_pop  = (tx_exp_q.size() > 0) &&
                   (lb_mode ? (rx_exp_q.size() < RXD) : bus.uart_in_ready);
         rx_push = !lb_mode && bus.uart_out_valid && (rx_exp_q.size() < RXD);
         rx_pop  = bus.core_rd_ready && (rx_exp_q.size() > 0);
         if (rx_pop) core_log.push_back(rx_exp_q.pop_front());
         if (tx_pop) begin
            b = tx_exp_q.pop_front();
            if (lb_mode) rx_exp_q.push_back(b);
            else         uart_log.push_back(b);
         end
         if (rx_push) rx_exp_q.push_back(bus.uart_out_data);
         if (tx_push) tx_exp_q.push_back(bus.core_wr_data);
         if (bus.core_led_valid)
            led_exp = (led_exp & ~bus.core_led_mask) | (bus.core_led_data & bus.core_led_mask);
`ifdef EXT_IO_BRIDGE_LOOPBACK_EN
         lb_mode = loopback;
`endif
      end
   end

   // Compare every output against the model away from the active edge.
   always @(negedge CLK) begin
      chk("core_wr_ready", {31'b0, bus.core_wr_ready}, {31'b0, tx_exp_q.size() < TXD});
      chk("uart_in_valid", {31'b0, bus.uart_in_valid}, {31'b0, (tx_exp_q.size() > 0) && !lb_mode});
      if (tx_exp_q.size() > 0) chk("uart_in_data", 32'(bus.uart_in_data), 32'(tx_exp_q[0]));
      chk("tx_level", 32'(tx_level), 32'(tx_exp_q.size()));
      chk("core_rd_valid", {31'b0, bus.core_rd_valid}, {31'b0, rx_exp_q.size() > 0});
      if (rx_exp_q.size() > 0) chk("core_rd_data", 32'(bus.core_rd_data), 32'(rx_exp_q[0]));
      chk("uart_out_ready", {31'b0, bus.uart_out_ready}, {31'b0, (rx_exp_q.size() < RXD) && !lb_mode});
      chk("rx_level", 32'(rx_level), 32'(rx_exp_q.size()));
      chk("LED", 32'(LED), 32'(led_exp));
      chk("core_led_out", 32'(bus.core_led_out), 32'(led_exp));
   end

   task automatic idle();
      bus.core_wr_valid  = 1'b0;
      bus.core_wr_data   = '0;
      bus.core_rd_ready  = 1'b0;
      bus.core_led_valid = 1'b0;
      bus.core_led_data  = '0;
      bus.core_led_mask  = '0;
      bus.uart_in_ready  = 1'b0;
      bus.uart_out_data  = '0;
      bus.uart_out_valid = 1'b0;
   endtask

   task automatic push_core(input logic [DW-1:0] b);
      bit ok;
      bus.core_wr_valid = 1'b1;
      bus.core_wr_data  = b;
      for (int i = 0; i < 50; i++) begin
         ok = bus.core_wr_ready;
         @(negedge CLK);
         if (ok) begin
            bus.core_wr_valid = 1'b0;
            return;
         end
      end
      bus.core_wr_valid = 1'b0;
      timeout_fail("push_core");
   endtask

   task automatic push_uart(input logic [DW-1:0] b);
      bit ok;
      bus.uart_out_valid = 1'b1;
      bus.uart_out_data  = b;
      for (int i = 0; i < 50; i++) begin
         ok = bus.uart_out_ready;
         @(negedge CLK);
         if (ok) begin
            bus.uart_out_valid = 1'b0;
            return;
         end
      end
      bus.uart_out_valid = 1'b0;
      timeout_fail("push_uart");
   endtask

   task automatic check_reset_values(input string tag);
      chk({tag, "_wr_ready"},  {31'b0, bus.core_wr_ready},  32'd1);
      chk({tag, "_rd_valid"},  {31'b0, bus.core_rd_valid},  32'd0);
      chk({tag, "_in_valid"},  {31'b0, bus.uart_in_valid},  32'd0);
      chk({tag, "_out_ready"}, {31'b0, bus.uart_out_ready}, 32'd1);
      chk({tag, "_tx_level"},  32'(tx_level), 32'd0);
      chk({tag, "_rx_level"},  32'(rx_level), 32'd0);
      chk({tag, "_LED"},       32'(LED), 32'h1);
      chk({tag, "_led_out"},   32'(bus.core_led_out), 32'h1);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [DW-1:0] tx_vals[5];
      bit            drained;
      tx_vals = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
      idle();
      RST_N = 1'b0;
      repeat (3) @(negedge CLK);
      check_reset_values("reset");
      RST_N = 1'b1;
      @(negedge CLK);

      // TX: fill to depth with the UART stalled, then drain.
      for (int i = 0; i < 5; i++) begin
         bus.core_wr_valid = 1'b1;
         bus.core_wr_data  = tx_vals[i];
         @(negedge CLK);
      end
      bus.core_wr_valid = 1'b0;
      chk("tx_full_level", 32'(tx_level), 32'd4);
      chk("tx_full_ready", {31'b0, bus.core_wr_ready}, 32'd0);
      uart_log.delete();
      bus.uart_in_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         chk("tx_drain_valid", {31'b0, bus.uart_in_valid}, 32'd1);
         chk("tx_drain_data", 32'(bus.uart_in_data), 32'(tx_vals[i]));
         @(negedge CLK);
      end
      bus.uart_in_ready = 1'b0;
      chk("tx_empty_valid", {31'b0, bus.uart_in_valid}, 32'd0);
      chk("tx_uart_count", 32'(uart_log.size()), 32'd4);
      for (int i = 0; i < uart_log.size() && i < 4; i++)
         chk("tx_uart_byte", 32'(uart_log[i]), 32'(tx_vals[i]));

      // RX: fill with the core stalled; a pop frees a slot for the next edge.
      core_log.delete();
      for (int k = 0; k < 4; k++) push_uart(8'hA0 + 8'(k));
      chk("rx_full_ready", {31'b0, bus.uart_out_ready}, 32'd0);
      chk("rx_full_level", 32'(rx_level), 32'd4);
      bus.uart_out_valid = 1'b1;
      bus.uart_out_data  = 8'hA4;
      bus.core_rd_ready  = 1'b1;
      chk("rx_head_first", 32'(bus.core_rd_data), 32'hA0);
      @(negedge CLK);
      bus.core_rd_ready = 1'b0;
      chk("rx_after_pop_ready", {31'b0, bus.uart_out_ready}, 32'd1);
      chk("rx_after_pop_level", 32'(rx_level), 32'd3);
      @(negedge CLK);
      chk("rx_a4_level", 32'(rx_level), 32'd4);
      chk("rx_a4_ready", {31'b0, bus.uart_out_ready}, 32'd0);
      bus.uart_out_valid = 1'b0;
      bus.core_rd_ready  = 1'b1;
      push_uart(8'hA5);
      drained = 1'b0;
      for (int i = 0; i < 20 && !drained; i++) begin
         if (rx_level == 0) drained = 1'b1;
         else @(negedge CLK);
      end
      bus.core_rd_ready = 1'b0;
      if (!drained) timeout_fail("rx_drain");
      chk("rx_core_count", 32'(core_log.size()), 32'd6);
      for (int i = 0; i < core_log.size() && i < 6; i++)
         chk("rx_core_byte", 32'(core_log[i]), 32'hA0 + 32'(i));

      // Concurrent push and pop at level 2 across pointer wrap.
      uart_log.delete();
      push_core(8'h30);
      push_core(8'h31);
      chk("conc_start_level", 32'(tx_level), 32'd2);
      bus.core_wr_valid = 1'b1;
      bus.uart_in_ready = 1'b1;
      for (int i = 0; i < 20; i++) begin
         bus.core_wr_data = 8'h32 + 8'(i);
         @(negedge CLK);
         chk("conc_level", 32'(tx_level), 32'd2);
      end
      bus.core_wr_valid = 1'b0;
      repeat (3) @(negedge CLK);
      bus.uart_in_ready = 1'b0;
      chk("conc_uart_count", 32'(uart_log.size()), 32'd22);
      for (int i = 0; i < uart_log.size() && i < 22; i++)
         chk("conc_uart_byte", 32'(uart_log[i]), 32'h30 + 32'(i));

      // LED masked writes.
      bus.core_led_valid = 1'b1;
      bus.core_led_data  = 4'b1111;
      bus.core_led_mask  = 4'b0101;
      @(negedge CLK);
      chk("led_write1", 32'(LED), 32'b0101);
      bus.core_led_data = 4'b0000;
      bus.core_led_mask = 4'b0001;
      @(negedge CLK);
      chk("led_write2", 32'(LED), 32'b0100);
      bus.core_led_valid = 1'b0;

      // Random traffic with one asynchronous reset in the middle.
      for (int cyc = 0; cyc < 1500; cyc++) begin
         bus.core_wr_valid  = 1'($urandom_range(0, 1));
         bus.core_wr_data   = 8'($urandom_range(0, 255));
         bus.uart_in_ready  = 1'($urandom_range(0, 1));
         bus.uart_out_valid = 1'($urandom_range(0, 1));
         bus.uart_out_data  = 8'($urandom_range(0, 255));
         bus.core_rd_ready  = 1'($urandom_range(0, 1));
         bus.core_led_valid = ($urandom_range(0, 3) == 0);
         bus.core_led_data  = 4'($urandom_range(0, 15));
         bus.core_led_mask  = 4'($urandom_range(0, 15));
`ifdef EXT_IO_BRIDGE_LOOPBACK_EN
         if ($urandom_range(0, 15) == 0) loopback = ~loopback;
`endif
         if (cyc == 700) begin
            #2 RST_N = 1'b0;
            #1 chk("midrst_tx_level", 32'(tx_level), 32'd0);
            chk("midrst_rx_level", 32'(rx_level), 32'd0);
            @(negedge CLK);
            check_reset_values("midrst");
            RST_N = 1'b1;
         end
         @(negedge CLK);
      end
      idle();

`ifdef EXT_IO_BRIDGE_LOOPBACK_EN
      // Loopback: TX bytes return on the core RX port and never reach the UART.
      loopback = 1'b1;
      @(negedge CLK);
      bus.core_rd_ready = 1'b1;
      repeat (6) @(negedge CLK);
      bus.core_rd_ready = 1'b0;
      push_core(8'h5A);
      drained = 1'b0;
      for (int i = 0; i < 20 && !drained; i++) begin
         chk("lb_uart_in_valid", {31'b0, bus.uart_in_valid}, 32'd0);
         if (bus.core_rd_valid) drained = 1'b1;
         else @(negedge CLK);
      end
      if (!drained) timeout_fail("lb_wait");
      else chk("lb_rd_data", 32'(bus.core_rd_data), 32'h5A);
      bus.core_wr_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         bus.core_wr_data = 8'h60 + 8'(i);
         @(negedge CLK);
      end
      #2 RST_N = 1'b0;
      #1 chk("lb_rst_tx_level", 32'(tx_level), 32'd0);
      chk("lb_rst_rx_level", 32'(rx_level), 32'd0);
      chk("lb_rst_rd_valid", {31'b0, bus.core_rd_valid}, 32'd0);
      loopback = 1'b0;
      idle();
      @(negedge CLK);
      RST_N = 1'b1;
      repeat (2) @(negedge CLK);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
